// File: rtl/vga_fb_mem_if.sv
// Single-port frame/tile memory bus as seen from the arbiter (master) and the macro (slave).
interface vga_fb_mem_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    modport master (output en, we, addr, wdata, input rdata);
    modport slave  (input en, we, addr, wdata, output rdata);
endinterface

// File: rtl/vga_fb_arbiter.sv
// Frame memory arbiter: display line bursts with priority, throttled every FAIR_GAP words
// so the game and sprite ports (round-robin between themselves) cannot starve.
//
// state    | meaning
// ST_IDLE  | no burst issuing; accepts disp_req_i, otherwise serves game/sprite by RR
// ST_BURST | issuing display reads base+idx; one RR slot inserted after FAIR_GAP words
module vga_fb_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int LINE_WORDS = 160,
    parameter int FAIR_GAP   = 8
) (
    input  logic                          clk100_i,
    input  logic                          rst_n_i,
    input  logic                          disp_req_i,
    input  logic [ADDR_W-1:0]             disp_base_i,
    output logic                          disp_busy_o,
    output logic                          disp_wr_o,
    output logic [$clog2(LINE_WORDS)-1:0] disp_idx_o,
    output logic [DATA_W-1:0]             disp_data_o,
    output logic                          disp_done_o,
    output logic                          disp_miss_o,
    input  logic                          gm_req_i,
    input  logic                          gm_we_i,
    input  logic [ADDR_W-1:0]             gm_addr_i,
    input  logic [DATA_W-1:0]             gm_wdata_i,
    output logic                          gm_gnt_o,
    output logic                          gm_rvalid_o,
    output logic [DATA_W-1:0]             gm_rdata_o,
    input  logic                          sp_req_i,
    input  logic [ADDR_W-1:0]             sp_addr_i,
    output logic                          sp_gnt_o,
    output logic                          sp_rvalid_o,
    output logic [DATA_W-1:0]             sp_rdata_o,
    vga_fb_mem_if.master                  mem
);
    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int GAP_W = $clog2(FAIR_GAP + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);
    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(FAIR_GAP);

    typedef enum logic {ST_IDLE, ST_BURST} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              rr_q, rr_d;
    logic              busy_q, busy_d;
    logic              miss_q, miss_d;
    logic              en_q, en_d, we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              gm_gnt_q, gm_gnt_d, sp_gnt_q, sp_gnt_d;
    logic              iss_disp_q, iss_disp_d, iss_last_q, iss_last_d;
    logic [IDX_W-1:0]  iss_idx_q, iss_idx_d;
    logic              disp_wr_q, disp_wr_d, done_q, done_d;
    logic [IDX_W-1:0]  disp_idx_q, disp_idx_d;
    logic              gm_rvalid_q, gm_rvalid_d, sp_rvalid_q, sp_rvalid_d;
    logic [DATA_W-1:0] disp_hold_q, disp_hold_d, gm_hold_q, gm_hold_d, sp_hold_q, sp_hold_d;

    logic gm_elig, sp_elig, pick_sp, disp_start, do_rr;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        idx_d      = idx_q;
        gap_d      = gap_q;
        rr_d       = rr_q;
        busy_d     = busy_q;
        en_d       = 1'b0;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        gm_gnt_d   = 1'b0;
        sp_gnt_d   = 1'b0;
        iss_disp_d = 1'b0;
        iss_last_d = 1'b0;
        iss_idx_d  = iss_idx_q;
        do_rr      = 1'b0;

        // A port granted last cycle sits out this one, so the RR partner gets the slot.
        gm_elig    = gm_req_i & ~gm_gnt_q;
        sp_elig    = sp_req_i & ~sp_gnt_q;
        pick_sp    = sp_elig & (~gm_elig | rr_q);
        disp_start = disp_req_i & ~busy_q & (state_q == ST_IDLE);
        miss_d     = disp_req_i & busy_q;

        case (state_q)
            ST_IDLE: begin
                if (disp_start) begin
                    base_d     = disp_base_i;
                    en_d       = 1'b1;
                    addr_d     = disp_base_i;
                    iss_disp_d = 1'b1;
                    iss_idx_d  = '0;
                    idx_d      = IDX_W'(1);
                    gap_d      = GAP_W'(1);
                    busy_d     = 1'b1;
                    state_d    = ST_BURST;
                end else begin
                    do_rr = 1'b1;
                end
            end
            ST_BURST: begin
                if ((gap_q == GAP_MAX) && (gm_elig | sp_elig)) begin
                    do_rr = 1'b1;
                    gap_d = '0;
                end else begin
                    en_d       = 1'b1;
                    addr_d     = base_q + ADDR_W'(idx_q);
                    iss_disp_d = 1'b1;
                    iss_idx_d  = idx_q;
                    gap_d      = (gap_q == GAP_MAX) ? gap_q : gap_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        iss_last_d = 1'b1;
                        idx_d      = '0;
                        gap_d      = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (do_rr && (gm_elig | sp_elig)) begin
            en_d = 1'b1;
            if (pick_sp) begin
                sp_gnt_d = 1'b1;
                addr_d   = sp_addr_i;
                rr_d     = 1'b0;
            end else begin
                gm_gnt_d = 1'b1;
                we_d     = gm_we_i;
                addr_d   = gm_addr_i;
                wdata_d  = gm_wdata_i;
                rr_d     = 1'b1;
            end
        end

        // busy stays up until the cycle after the last word lands in the line buffer
        if (done_q) busy_d = 1'b0;
    end

    always_comb begin
        disp_wr_d   = iss_disp_q;
        disp_idx_d  = iss_disp_q ? iss_idx_q : disp_idx_q;
        done_d      = iss_disp_q & iss_last_q;
        gm_rvalid_d = gm_gnt_q & ~we_q;
        sp_rvalid_d = sp_gnt_q;
        disp_hold_d = disp_wr_q   ? mem.rdata : disp_hold_q;
        gm_hold_d   = gm_rvalid_q ? mem.rdata : gm_hold_q;
        sp_hold_d   = sp_rvalid_q ? mem.rdata : sp_hold_q;
    end

    always_ff @(posedge clk100_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            idx_q       <= '0;
            gap_q       <= '0;
            rr_q        <= 1'b0;
            busy_q      <= 1'b0;
            miss_q      <= 1'b0;
            en_q        <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            gm_gnt_q    <= 1'b0;
            sp_gnt_q    <= 1'b0;
            iss_disp_q  <= 1'b0;
            iss_last_q  <= 1'b0;
            iss_idx_q   <= '0;
            disp_wr_q   <= 1'b0;
            disp_idx_q  <= '0;
            done_q      <= 1'b0;
            gm_rvalid_q <= 1'b0;
            sp_rvalid_q <= 1'b0;
            disp_hold_q <= '0;
            gm_hold_q   <= '0;
            sp_hold_q   <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            idx_q       <= idx_d;
            gap_q       <= gap_d;
            rr_q        <= rr_d;
            busy_q      <= busy_d;
            miss_q      <= miss_d;
            en_q        <= en_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            gm_gnt_q    <= gm_gnt_d;
            sp_gnt_q    <= sp_gnt_d;
            iss_disp_q  <= iss_disp_d;
            iss_last_q  <= iss_last_d;
            iss_idx_q   <= iss_idx_d;
            disp_wr_q   <= disp_wr_d;
            disp_idx_q  <= disp_idx_d;
            done_q      <= done_d;
            gm_rvalid_q <= gm_rvalid_d;
            sp_rvalid_q <= sp_rvalid_d;
            disp_hold_q <= disp_hold_d;
            gm_hold_q   <= gm_hold_d;
            sp_hold_q   <= sp_hold_d;
        end
    end

    // Read data is forwarded from the macro in its valid cycle and held afterwards.
    assign disp_busy_o = busy_q;
    assign disp_wr_o   = disp_wr_q;
    assign disp_idx_o  = disp_idx_q;
    assign disp_data_o = disp_wr_q ? mem.rdata : disp_hold_q;
    assign disp_done_o = done_q;
    assign disp_miss_o = miss_q;
    assign gm_gnt_o    = gm_gnt_q;
    assign gm_rvalid_o = gm_rvalid_q;
    assign gm_rdata_o  = gm_rvalid_q ? mem.rdata : gm_hold_q;
    assign sp_gnt_o    = sp_gnt_q;
    assign sp_rvalid_o = sp_rvalid_q;
    assign sp_rdata_o  = sp_rvalid_q ? mem.rdata : sp_hold_q;
    assign mem.en      = en_q;
    assign mem.we      = we_q;
    assign mem.addr    = addr_q;
    assign mem.wdata   = wdata_q;
endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
Arbitrates one single-port synchronous frame/tile memory between three requesters: the VGA line fetcher (display burst), the game-logic port (read/write) and the sprite engine (read only). The display burst has priority, but it is throttled so the other two ports cannot starve. Game and sprite ports share the remaining slots round-robin. The block sits between the pixel-timing generator, the game core and the memory macro, all in the VGA pixel-clock domain.

Parameters:
ADDR_W, 16, memory address width
DATA_W, 8, memory word width
LINE_WORDS, 160, words per display burst (one scanline)
FAIR_GAP, 8, max consecutive display words before one pending game/sprite slot is inserted

Ports:
clk100_i  in  1  clock (all logic on rising edge)
rst_n_i  in  1  asynchronous active-low reset
disp_req_i  in  1  single-cycle pulse: start line burst
disp_base_i  in  ADDR_W  burst start address, sampled with disp_req_i
disp_busy_o  out  1  burst in progress
disp_wr_o  out  1  line-buffer write strobe (read data valid)
disp_idx_o  out  $clog2(LINE_WORDS)  line-buffer index for disp_data_o
disp_data_o  out  DATA_W  fetched word
disp_done_o  out  1  one-cycle pulse with the last disp_wr_o
disp_miss_o  out  1  one-cycle pulse: disp_req_i arrived while busy
gm_req_i  in  1  game access request, level, held until granted
gm_we_i  in  1  1 = write, 0 = read
gm_addr_i  in  ADDR_W  game address
gm_wdata_i  in  DATA_W  game write data
gm_gnt_o  out  1  one-cycle grant: access issued this cycle
gm_rvalid_o  out  1  game read data valid
gm_rdata_o  out  DATA_W  game read data
sp_req_i  in  1  sprite read request, level, held until granted
sp_addr_i  in  ADDR_W  sprite address
sp_gnt_o  out  1  one-cycle grant
sp_rvalid_o  out  1  sprite read data valid
sp_rdata_o  out  DATA_W  sprite read data
mem_en_o  out  1  memory enable
mem_we_o  out  1  memory write enable
mem_addr_o  out  ADDR_W  memory address
mem_wdata_o  out  DATA_W  memory write data
mem_rdata_i  in  DATA_W  read data, valid one cycle after mem_en_o & !mem_we_o

Behaviour:
- Reset (async assert, sync release): all outputs 0. State IDLE. Burst counter, gap counter and RR pointer are 0, and the RR pointer favours game first. A reset mid-burst aborts the burst with no disp_done_o, and any in-flight read data is discarded.
- All outputs are registered. A decision is made in cycle N from the inputs at N. In cycle N+1, mem_* and the matching gnt_o carry the address and data captured at N. Read data appears on *_rdata_o with *_rvalid_o/disp_wr_o at N+2.
- One memory access per cycle at most. mem_en_o=0 when nothing is granted.
- Requester eligibility: a port is not eligible in the cycle its gnt_o is high. Game and sprite therefore get at most one access per 2 cycles; the requester may change or drop its req in the gnt cycle.
- States:
  - IDLE: accepts disp_req_i. Otherwise serves game/sprite by RR.
  - BURST: disp_busy_o=1. Issues display reads at disp_base+idx, idx 0..LINE_WORDS-1, one per cycle. The gap counter counts consecutive display issues. When it reaches FAIR_GAP and game or sprite is eligible, the next slot goes to the RR winner and the gap counter clears. If neither is pending, display continues.
  - After the last display issue: back to IDLE. disp_busy_o falls in the cycle after disp_done_o.
- RR: on a grant, the pointer moves to the other port. If only one port is requesting, it wins.
- disp_req_i with disp_busy_o=1: ignored, base is not resampled, disp_miss_o pulses.
- disp_req_i in IDLE with game/sprite also pending: display wins that slot.
- Address arithmetic is modulo 2^ADDR_W, so the burst wraps past the top address.
- gm write: mem_we_o=1, and no gm_rvalid_o follows.
- disp_idx_o and disp_data_o hold their last values when disp_wr_o=0.

Test Plan:
- Reset: drive rst_n_i low mid-burst at idx 40 -> all outputs 0 asynchronously; after release, no disp_done_o and no stale disp_wr_o.
- Lone burst, disp_base_i=0x1000, LINE_WORDS=160, no other requests -> mem_addr_o 0x1000..0x109F on 160 consecutive cycles; disp_wr_o idx 0..159 with the preloaded data; disp_done_o at idx 159.
- Burst with gm_req_i held, write 0x55 to 0x0200 -> after exactly 8 display words one game write is issued (mem_we_o=1, addr 0x0200), then display resumes; the burst takes 161 issue cycles.
- Game and sprite both held with reads, no burst -> grants alternate gm, sp, gm, sp, … and each rvalid appears 1 cycle after its gnt with the correct data.
- Second disp_req_i at idx 10 -> disp_miss_o=1 for one cycle; the burst continues unchanged from the original base.
- disp_base_i=0xFFF0, LINE_WORDS=160 -> addresses wrap 0xFFFF→0x0000; the last address is 0x008F.
